// File: rtl/uart_mmio_ctrl_if.sv
// rv_if: byte-wide ready/valid link between the MMIO controller and the UART
interface rv_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO register front-end with TX/RX byte FIFOs; define UART_CTRL_LOOPBACK_EN for CTRL[2] loopback
module uart_mmio_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_en,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  rv_if.TX            send_req,
  rv_if.RX            recv_rsp,
  output logic        irq
);
  localparam int TA = $clog2(TX_DEPTH);
  localparam int RA = $clog2(RX_DEPTH);
  logic [7:0]  tx_mem [TX_DEPTH];
  logic [7:0]  rx_mem [RX_DEPTH];
  logic [TA:0] tx_wp, tx_rp;
  logic [RA:0] rx_wp, rx_rp, rx_cnt;
  logic [2:0]  ctrl;
  logic [1:0]  a;
  logic        rx_ovf, tx_ovf, lpbk, wr, rd;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_pop, tx_push, tx_ovf_set, rx_pop, rx_in, rx_push, rx_ovf_set;
  logic [7:0]  tx_head, rx_head, rx_din;
  logic [31:0] status, rdata_d;
  logic        unused;
`ifdef UART_CTRL_LOOPBACK_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
  assign lpbk = ctrl[2];
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
  assign lpbk = 1'b0;
`endif
  assign unused = ^{bus_wdata[31:8], bus_addr[1:0]};
  assign send_req.valid = !tx_empty && !lpbk;
  assign send_req.data = tx_head;
  assign recv_rsp.ready = 1'b1;
  always_comb begin
    a = bus_addr[3:2];
    wr = bus_en && bus_we;
    rd = bus_en && !bus_we;
    tx_empty = tx_wp == tx_rp;
    tx_full = tx_wp == {~tx_rp[TA], tx_rp[TA-1:0]};
    rx_empty = rx_wp == rx_rp;
    rx_full = rx_wp == {~rx_rp[RA], rx_rp[RA-1:0]};
    rx_cnt = rx_wp - rx_rp;
    tx_head = tx_mem[tx_rp[TA-1:0]];
    rx_head = rx_mem[rx_rp[RA-1:0]];
    tx_pop = lpbk ? !tx_empty && !rx_full : !tx_empty && send_req.ready;
    tx_push = wr && a == 2'd2 && (!tx_full || tx_pop);
    tx_ovf_set = wr && a == 2'd2 && tx_full && !tx_pop;
    rx_pop = rd && a == 2'd3 && !rx_empty;
    rx_in = lpbk ? tx_pop : recv_rsp.valid;
    rx_din = lpbk ? tx_head : recv_rsp.data;
    rx_push = rx_in && (!rx_full || rx_pop);
    rx_ovf_set = !lpbk && recv_rsp.valid && rx_full && !rx_pop;
    status = {16'd0, 8'(rx_cnt), 3'd0, tx_ovf, rx_ovf, tx_empty, tx_full, !rx_empty};
    rdata_d = a == 2'd0 ? status :
              a == 2'd1 ? {29'd0, ctrl} :
              a == 2'd3 ? (rx_empty ? 32'h8000_0000 : {24'd0, rx_head}) : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TA-1:0]] <= bus_wdata[7:0];
    if (rx_push) rx_mem[rx_wp[RA-1:0]] <= rx_din;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      ctrl <= '0;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      bus_rdata <= '0;
      bus_rvalid <= 1'b0;
      irq <= 1'b0;
    end else begin
      tx_wp <= tx_push ? tx_wp + 1'b1 : tx_wp;
      tx_rp <= tx_pop ? tx_rp + 1'b1 : tx_rp;
      rx_wp <= rx_push ? rx_wp + 1'b1 : rx_wp;
      rx_rp <= rx_pop ? rx_rp + 1'b1 : rx_rp;
      ctrl <= wr && a == 2'd1 ? bus_wdata[2:0] & CTRL_MASK : ctrl;
      tx_ovf <= tx_ovf_set || (tx_ovf && !(wr && a == 2'd0 && bus_wdata[4]));
      rx_ovf <= rx_ovf_set || (rx_ovf && !(wr && a == 2'd0 && bus_wdata[3]));
      bus_rdata <= rd ? rdata_d : bus_rdata;
      bus_rvalid <= rd;
      irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty);
    end
  end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: directed self-checking bench for uart_mmio_ctrl
module tb_uart_mmio_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_en = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_addr = 4'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        irq;
  int          tests = 0;
  int          fails = 0;
  rv_if tx_if();
  rv_if rx_if();
  always #5 clk = ~clk;
  uart_mmio_ctrl #(.TX_DEPTH(4), .RX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .send_req(tx_if), .recv_rsp(rx_if), .irq(irq)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_en = 1'b1;
    bus_we = 1'b1;
    bus_addr = a;
    bus_wdata = d;
    tick();
    bus_en = 1'b0;
    bus_we = 1'b0;
  endtask
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    bus_en = 1'b1;
    bus_we = 1'b0;
    bus_addr = a;
    tick();
    d = bus_rdata;
    v = bus_rvalid;
    bus_en = 1'b0;
  endtask
  task automatic push_rx(input logic [7:0] b);
    rx_if.valid = 1'b1;
    rx_if.data = b;
    tick();
    rx_if.valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    rst = 1'b0;
    tick();
    tick();
    tests++; if (bus_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h want 0", bus_rdata); end
    tests++; if (bus_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b want 0", bus_rvalid); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
    tests++; if (tx_if.valid !== 1'b0) begin fails++; $display("FAIL reset_txvalid: got %b want 0", tx_if.valid); end
    rst = 1'b1;
    tests++; if (rx_if.ready !== 1'b1) begin fails++; $display("FAIL reset_rxready: got %b want 1", rx_if.ready); end
    bus_read(4'h0, d, v);
    tests++; if (d !== 32'h4 || v !== 1'b1) begin fails++; $display("FAIL reset_status: got %h/%b want 00000004/1", d, v); end
    bus_read(4'h4, d, v);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h want 0", d); end
    bus_read(4'h8, d, v);
    tests++; if (d !== 32'h0 || v !== 1'b1) begin fails++; $display("FAIL txdata_read: got %h/%b want 0/1", d, v); end
  endtask

  task automatic test_tx_stall();
    logic [31:0] d;
    logic v;
    tx_if.ready = 1'b0;
    bus_write(4'h8, 32'h55);
    bus_write(4'h8, 32'hA3);
    for (int i = 0; i < 10; i++) begin
      tests++; if (tx_if.valid !== 1'b1 || tx_if.data !== 8'h55) begin fails++; $display("FAIL tx_stall_hold: got %b/%h want 1/55", tx_if.valid, tx_if.data); end
      tick();
    end
    tx_if.ready = 1'b1;
    tests++; if (tx_if.data !== 8'h55) begin fails++; $display("FAIL tx_first: got %h want 55", tx_if.data); end
    tick();
    tests++; if (tx_if.valid !== 1'b1 || tx_if.data !== 8'hA3) begin fails++; $display("FAIL tx_second: got %b/%h want 1/a3", tx_if.valid, tx_if.data); end
    tick();
    tests++; if (tx_if.valid !== 1'b0) begin fails++; $display("FAIL tx_drained: got %b want 0", tx_if.valid); end
    tx_if.ready = 1'b0;
    bus_read(4'h0, d, v);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL tx_empty_status: got %h want 00000004", d); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    logic v;
    tx_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(4'h8, 32'h10 + i);
    bus_read(4'h0, d, v);
    tests++; if (d !== 32'h12) begin fails++; $display("FAIL tx_ovf_status: got %h want 00000012", d); end
    bus_write(4'h0, 32'h10);
    bus_read(4'h0, d, v);
    tests++; if (d !== 32'h02) begin fails++; $display("FAIL tx_ovf_w1c: got %h want 00000002", d); end
    tx_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (tx_if.valid !== 1'b1 || tx_if.data !== 8'(8'h10 + i)) begin fails++; $display("FAIL tx_ovf_drain%0d: got %b/%h want 1/%h", i, tx_if.valid, tx_if.data, 8'(8'h10 + i)); end
      tick();
    end
    tx_if.ready = 1'b0;
    tests++; if (tx_if.valid !== 1'b0) begin fails++; $display("FAIL tx_ovf_dropped: got %b want 0", tx_if.valid); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d;
    logic v;
    for (int i = 0; i < 9; i++) push_rx(8'(i));
    bus_read(4'h0, d, v);
    tests++; if (d !== 32'h080D) begin fails++; $display("FAIL rx_ovf_status: got %h want 0000080d", d); end
    for (int i = 0; i < 8; i++) begin
      bus_read(4'hC, d, v);
      tests++; if (d !== 32'(i)) begin fails++; $display("FAIL rx_read%0d: got %h want %h", i, d, 32'(i)); end
    end
    bus_read(4'hC, d, v);
    tests++; if (d !== 32'h8000_0000 || v !== 1'b1) begin fails++; $display("FAIL rx_empty_read: got %h/%b want 80000000/1", d, v); end
    bus_write(4'h0, 32'h08);
    bus_read(4'h0, d, v);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL rx_ovf_w1c: got %h want 00000004", d); end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] d;
    logic v;
    for (int i = 0; i < 8; i++) push_rx(8'(i));
    bus_en = 1'b1;
    bus_we = 1'b0;
    bus_addr = 4'hC;
    rx_if.valid = 1'b1;
    rx_if.data = 8'h09;
    tick();
    bus_en = 1'b0;
    rx_if.valid = 1'b0;
    tests++; if (bus_rdata !== 32'h0) begin fails++; $display("FAIL full_pop_read: got %h want 0", bus_rdata); end
    bus_read(4'h0, d, v);
    tests++; if (d !== 32'h0805) begin fails++; $display("FAIL full_pop_status: got %h want 00000805", d); end
    for (int i = 1; i < 9; i++) begin
      bus_read(4'hC, d, v);
      tests++; if (d !== (i == 8 ? 32'h9 : 32'(i))) begin fails++; $display("FAIL full_pop_read%0d: got %h want %h", i, d, (i == 8 ? 32'h9 : 32'(i))); end
    end
    bus_read(4'hC, d, v);
    tests++; if (d !== 32'h8000_0000) begin fails++; $display("FAIL full_pop_empty: got %h want 80000000", d); end
  endtask

  task automatic test_empty_arrive_read();
    logic [31:0] d;
    logic v;
    bus_en = 1'b1;
    bus_we = 1'b0;
    bus_addr = 4'hC;
    rx_if.valid = 1'b1;
    rx_if.data = 8'h42;
    tick();
    bus_en = 1'b0;
    rx_if.valid = 1'b0;
    tests++; if (bus_rdata !== 32'h8000_0000) begin fails++; $display("FAIL empty_arrive_read: got %h want 80000000", bus_rdata); end
    bus_read(4'hC, d, v);
    tests++; if (d !== 32'h42) begin fails++; $display("FAIL empty_arrive_stored: got %h want 42", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic v;
    bus_write(4'h4, 32'h1);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b want 0", irq); end
    push_rx(8'h77);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_lag: got %b want 0", irq); end
    tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_rise: got %b want 1", irq); end
    bus_read(4'hC, d, v);
    tests++; if (irq !== 1'b1 || d !== 32'h77) begin fails++; $display("FAIL irq_pop: got %b/%h want 1/77", irq, d); end
    tick();
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_fall: got %b want 0", irq); end
    bus_write(4'h4, 32'h2);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_tx_lag: got %b want 0", irq); end
    tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
    bus_read(4'h4, d, v);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL ctrl_readback: got %h want 2", d); end
    bus_write(4'h4, 32'h0);
    tick();
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_disabled: got %b want 0", irq); end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    logic v;
`ifdef UART_CTRL_LOOPBACK_EN
    tx_if.ready = 1'b1;
    bus_write(4'h4, 32'h4);
    bus_write(4'h8, 32'h3C);
    tests++; if (tx_if.valid !== 1'b0) begin fails++; $display("FAIL lpbk_valid: got %b want 0", tx_if.valid); end
    tick();
    tests++; if (tx_if.valid !== 1'b0) begin fails++; $display("FAIL lpbk_valid2: got %b want 0", tx_if.valid); end
    bus_read(4'hC, d, v);
    tests++; if (d !== 32'h3C) begin fails++; $display("FAIL lpbk_data: got %h want 3c", d); end
    bus_read(4'h4, d, v);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL lpbk_ctrl: got %h want 4", d); end
    tx_if.ready = 1'b0;
`else
    bus_write(4'h4, 32'h7);
    bus_read(4'h4, d, v);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL ctrl_no_lpbk: got %h want 3", d); end
`endif
    bus_write(4'h4, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    tx_if.ready = 1'b0;
    bus_write(4'h8, 32'h99);
    push_rx(8'h11);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tests++; if (tx_if.valid !== 1'b0) begin fails++; $display("FAIL mid_reset_txvalid: got %b want 0", tx_if.valid); end
    bus_read(4'h0, d, v);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL mid_reset_status: got %h want 00000004", d); end
    bus_read(4'hC, d, v);
    tests++; if (d !== 32'h8000_0000) begin fails++; $display("FAIL mid_reset_rx: got %h want 80000000", d); end
  endtask

  initial begin
    tx_if.ready = 1'b0;
    rx_if.valid = 1'b0;
    rx_if.data = 8'h00;
    test_reset();
    test_tx_stall();
    test_tx_overflow();
    test_rx_overflow();
    test_full_pop_push();
    test_empty_arrive_read();
    test_irq();
    test_loopback();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
